mc_mem_unit: RTL and testbench

- Memory-side responder for the multicycle MIPS control unit.
- Consumes memread, memwrite, iord and irwrite from the controller, plus the PC, ALUOut and B operands from the datapath.
- Services each request from a word-organised RAM with a configurable read latency.
- Holds the Instruction Register and Memory Data Register, and signals completion with mem_ready so the controller can stall in its fetch and memory-access states.

---
 rtl/mc_mem_unit.sv | 150 +++++++++++++++
 tb/tb_mc_mem_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mc_mem_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mc_mem_unit
//  Purpose  : Memory-side responder for the multicycle MIPS control unit.
//             Services controller read/write requests from a word-organised
//             RAM with a configurable read latency. It holds the Instruction
//             Register and the Memory Data Register, and pulses mem_ready so
//             the controller can stall in its fetch and memory states.
//  Ports    : clk, reset (async, active-high)
//             memread, memwrite, iord, irwrite   - controller requests
//             pc, aluout, wdata                  - datapath operands
//             ir, mdr                            - IR / MDR outputs
//             mem_ready (1-cycle pulse), busy, err (sticky)
//  Revision : 1.0 - initial release
// ============================================================================
module mc_mem_unit #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memread,
    input  logic              memwrite,
    input  logic              iord,
    input  logic              irwrite,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] aluout,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] ir,
    output logic [DATA_W-1:0] mdr,
    output logic              mem_ready,
    output logic              busy,
    output logic              err
);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_RD_WAIT = 2'd1;
    localparam logic [1:0] c_ST_DONE    = 2'd2;
    localparam logic [3:0] c_LAT_INIT   = 4'(RD_LAT - 1);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    logic [1:0]        r_state;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_idx;
    logic              r_irw;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_mdr;
    logic              r_ready;
    logic              r_busy;
    logic              r_err;

    logic [DATA_W-1:0] w_addr;
    logic [ADDR_W-1:0] w_idx;
    logic              w_misalign;
    logic              w_idle;
    logic              w_accept_wr;
    logic              w_accept_rd;

    // Byte address to word index; high bits above the RAM depth are dropped
    // so accesses wrap modulo the depth.
    assign w_addr      = iord ? aluout : pc;
    assign w_idx       = w_addr[ADDR_W+1:2];
    assign w_misalign  = |w_addr[1:0];
    assign w_idle      = (r_state == c_ST_IDLE);
    // A write wins when both requests are raised; the read is dropped.
    assign w_accept_wr = w_idle && memwrite;
    assign w_accept_rd = w_idle && memread && !memwrite;

    generate
        if (ADDR_W + 2 < DATA_W) begin : g_addr_hi
            logic w_unused_addr_hi;
            assign w_unused_addr_hi = ^w_addr[DATA_W-1:ADDR_W+2];
        end
    endgenerate

    // RAM contents are never reset; a write coinciding with reset is
    // suppressed so an aborted access leaves memory untouched.
    always_ff @(posedge clk) begin
        if (w_accept_wr && !reset) begin
            r_mem[w_idx] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= 4'd0;
            r_idx   <= '0;
            r_irw   <= 1'b0;
            r_ir    <= '0;
            r_mdr   <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (memread || memwrite) begin
                        if (w_misalign || (memread && memwrite)) begin
                            r_err <= 1'b1;
                        end
                        r_busy <= 1'b1;
                    end
                    if (w_accept_wr) begin
                        r_state <= c_ST_DONE;
                        r_ready <= 1'b1;
                    end else if (w_accept_rd) begin
                        // Capture the address so later pc/aluout/iord
                        // changes cannot disturb the access.
                        r_idx   <= w_idx;
                        r_irw   <= irwrite;
                        r_cnt   <= c_LAT_INIT;
                        r_state <= c_ST_RD_WAIT;
                    end
                end
                c_ST_RD_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_mdr <= r_mem[r_idx];
                        if (r_irw) begin
                            r_ir <= r_mem[r_idx];
                        end
                        r_state <= c_ST_DONE;
                        r_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ir        = r_ir;
    assign mdr       = r_mdr;
    assign mem_ready = r_ready;
    assign busy      = r_busy;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mc_mem_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mc_mem_unit
//  Purpose  : Directed self-checking bench for mc_mem_unit (RD_LAT=2,
//             ADDR_W=8). Inputs change and outputs are sampled on the
//             falling edge, away from the active rising edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mc_mem_unit;

    logic        clk;
    logic        reset;
    logic        memread;
    logic        memwrite;
    logic        iord;
    logic        irwrite;
    logic [31:0] pc;
    logic [31:0] aluout;
    logic [31:0] wdata;
    logic [31:0] ir;
    logic [31:0] mdr;
    logic        mem_ready;
    logic        busy;
    logic        err;

    int total;
    int bad;

    mc_mem_unit #(.ADDR_W(8), .DATA_W(32), .RD_LAT(2)) dut (
        .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
        .iord(iord), .irwrite(irwrite), .pc(pc), .aluout(aluout),
        .wdata(wdata), .ir(ir), .mdr(mdr), .mem_ready(mem_ready),
        .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus-only helper: single write through aluout, request dropped
    // after the accept edge, ends with the unit back in IDLE.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        memwrite = 1'b1; iord = 1'b1; aluout = a; wdata = d;
        @(negedge clk);
        memwrite = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1; memread = 0; memwrite = 0; iord = 0; irwrite = 0;
        pc = 0; aluout = 0; wdata = 0;
        repeat (3) @(negedge clk);
        total++; if (ir !== 32'h0) begin bad++; $display("FAIL reset_ir got=%h exp=0", ir); end
        total++; if (mdr !== 32'h0) begin bad++; $display("FAIL reset_mdr got=%h exp=0", mdr); end
        total++; if (mem_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", mem_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_read;
        @(negedge clk);
        memwrite = 1; iord = 1; aluout = 32'h10; wdata = 32'hDEADBEEF;
        @(negedge clk);
        total++; if (mem_ready !== 1'b1) begin bad++; $display("FAIL wr_ready got=%b exp=1", mem_ready); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL wr_busy got=%b exp=1", busy); end
        memwrite = 0;
        @(negedge clk);
        total++; if (mem_ready !== 1'b0) begin bad++; $display("FAIL wr_ready_pulse got=%b exp=0", mem_ready); end
        // read back the same word, irwrite=0
        memread = 1; iord = 1; aluout = 32'h10; irwrite = 0;
        @(negedge clk);
        memread = 0;
        total++; if (mem_ready !== 1'b0) begin bad++; $display("FAIL rd_ready_c1 got=%b exp=0", mem_ready); end
        @(negedge clk);
        total++; if (mem_ready !== 1'b0) begin bad++; $display("FAIL rd_ready_c2 got=%b exp=0", mem_ready); end
        @(negedge clk);
        total++; if (mem_ready !== 1'b1) begin bad++; $display("FAIL rd_ready_c3 got=%b exp=1", mem_ready); end
        total++; if (mdr !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_mdr got=%h exp=deadbeef", mdr); end
        total++; if (ir !== 32'h0) begin bad++; $display("FAIL rd_ir_hold got=%h exp=0", ir); end
        @(negedge clk);
        total++; if (mem_ready !== 1'b0) begin bad++; $display("FAIL rd_ready_c4 got=%b exp=0", mem_ready); end
    endtask

    task automatic test_fetch;
        do_write(32'h0, 32'h8C220004);
        memread = 1; irwrite = 1; iord = 0; pc = 32'h0;
        @(negedge clk);
        memread = 0; irwrite = 0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL fetch_busy1 got=%b exp=1", busy); end
        @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL fetch_busy2 got=%b exp=1", busy); end
        @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL fetch_busy3 got=%b exp=1", busy); end
        total++; if (mem_ready !== 1'b1) begin bad++; $display("FAIL fetch_ready got=%b exp=1", mem_ready); end
        total++; if (ir !== 32'h8C220004) begin bad++; $display("FAIL fetch_ir got=%h exp=8c220004", ir); end
        total++; if (mdr !== 32'h8C220004) begin bad++; $display("FAIL fetch_mdr got=%h exp=8c220004", mdr); end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL fetch_busy4 got=%b exp=0", busy); end
    endtask

    task automatic test_addr_capture;
        do_write(32'h40, 32'h12345678);
        memread = 1; iord = 0; pc = 32'h0; irwrite = 0;
        @(negedge clk);
        memread = 0; pc = 32'h40; iord = 1; aluout = 32'h40;
        @(negedge clk);
        @(negedge clk);
        total++; if (mem_ready !== 1'b1) begin bad++; $display("FAIL cap_ready got=%b exp=1", mem_ready); end
        total++; if (mdr !== 32'h8C220004) begin bad++; $display("FAIL cap_mdr got=%h exp=8c220004", mdr); end
        total++; if (ir !== 32'h8C220004) begin bad++; $display("FAIL cap_ir_hold got=%h exp=8c220004", ir); end
        @(negedge clk);
    endtask

    task automatic test_simul;
        memread = 1; memwrite = 1; iord = 1; aluout = 32'h8; wdata = 32'h55;
        @(negedge clk);
        memread = 0; memwrite = 0;
        total++; if (mem_ready !== 1'b1) begin bad++; $display("FAIL rw_ready got=%b exp=1", mem_ready); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL rw_err got=%b exp=1", err); end
        total++; if (mdr !== 32'h8C220004) begin bad++; $display("FAIL rw_mdr_hold got=%h exp=8c220004", mdr); end
        @(negedge clk);
        memread = 1; iord = 1; aluout = 32'h8;
        @(negedge clk);
        memread = 0;
        repeat (2) @(negedge clk);
        total++; if (mdr !== 32'h55) begin bad++; $display("FAIL rw_word2 got=%h exp=55", mdr); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL rw_err_sticky got=%b exp=1", err); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        memwrite = 1; iord = 1; aluout = 32'hC; wdata = 32'hA5A5A5A5;
        @(negedge clk);
        total++; if (mem_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready1 got=%b exp=1", mem_ready); end
        @(negedge clk);
        total++; if (mem_ready !== 1'b0) begin bad++; $display("FAIL b2b_gap got=%b exp=0", mem_ready); end
        @(negedge clk);
        total++; if (mem_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready2 got=%b exp=1", mem_ready); end
        memwrite = 0;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid;
        int pulses;
        memread = 1; iord = 1; aluout = 32'h8; irwrite = 1;
        @(negedge clk);
        memread = 0; irwrite = 0;
        reset = 1;
        #1;
        total++; if (ir !== 32'h0) begin bad++; $display("FAIL rstmid_ir got=%h exp=0", ir); end
        total++; if (mdr !== 32'h0) begin bad++; $display("FAIL rstmid_mdr got=%h exp=0", mdr); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (mem_ready) pulses++;
            if (i == 1) reset = 0;
        end
        total++; if (pulses !== 0) begin bad++; $display("FAIL rstmid_pulses got=%0d exp=0", pulses); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rstmid_err got=%b exp=0", err); end
        memread = 1; iord = 1; aluout = 32'h8; irwrite = 1;
        @(negedge clk);
        memread = 0; irwrite = 0;
        repeat (2) @(negedge clk);
        total++; if (mem_ready !== 1'b1) begin bad++; $display("FAIL rstmid_next_ready got=%b exp=1", mem_ready); end
        total++; if (ir !== 32'h55) begin bad++; $display("FAIL rstmid_next_ir got=%h exp=55", ir); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rstmid_next_err got=%b exp=0", err); end
        @(negedge clk);
    endtask

    task automatic test_misaligned_wrap;
        memread = 1; iord = 1; aluout = 32'h402; irwrite = 0;
        @(negedge clk);
        memread = 0;
        total++; if (err !== 1'b1) begin bad++; $display("FAIL mis_err got=%b exp=1", err); end
        repeat (2) @(negedge clk);
        total++; if (mdr !== 32'h8C220004) begin bad++; $display("FAIL mis_word0 got=%h exp=8c220004", mdr); end
        @(negedge clk);
        do_write(32'h3FC, 32'hCAFEF00D);
        // 0xFFC also maps to word 255
        memread = 1; iord = 0; pc = 32'hFFC;
        @(negedge clk);
        memread = 0;
        repeat (2) @(negedge clk);
        total++; if (mdr !== 32'hCAFEF00D) begin bad++; $display("FAIL wrap_word255 got=%h exp=cafef00d", mdr); end
        @(negedge clk);
        memread = 1; iord = 0; pc = 32'h0;
        @(negedge clk);
        memread = 0;
        repeat (2) @(negedge clk);
        total++; if (mdr !== 32'h8C220004) begin bad++; $display("FAIL wrap_word0_intact got=%h exp=8c220004", mdr); end
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_write_read();
        test_fetch();
        test_addr_capture();
        test_simul();
        test_back_to_back();
        test_reset_mid();
        test_misaligned_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
